// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and default sizing for the memory bus controller.
package mem_bus_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int unsigned DEF_ADDR_WIDTH = 16;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam logic [15:0] DEF_ROM_BASE   = 16'hF000;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Request/response handshake between the 6502 address/data unit (master)
// and the memory bus controller (slave).
interface mem_bus_ctrl_if
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_we;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_addr, req_we, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: one byte read/write per handshake, registered
// strobes to the memory, programmable read latency, one-cycle response.
// Optional write protection above ROM_BASE: define MEM_BUS_CTRL_WPROT_EN.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
`ifdef MEM_BUS_CTRL_WPROT_EN
    parameter logic [ADDR_WIDTH-1:0] ROM_BASE = ADDR_WIDTH'(DEF_ROM_BASE),
`endif
    parameter int unsigned RD_LATENCY = 1
)(
    input  logic                  clk,
    input  logic                  resetn,
    mem_bus_ctrl_if.slave         bus,
    output logic                  busy,
    output logic                  mem_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_wr_enable,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    localparam int unsigned CNT_W = $clog2(RD_LATENCY + 1);

    if (RD_LATENCY == 0) begin : g_rd_latency_check
        $error("mem_bus_ctrl: RD_LATENCY must be >= 1");
    end

    state_t                state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  en_q, en_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rv_q, rv_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  blocked;
`ifdef MEM_BUS_CTRL_WPROT_EN
    logic                  blk_q, blk_d;
    logic                  err_q, err_d;
`endif

    // Blocked writes never touch memory but still answer at T1.
    always_comb begin
`ifdef MEM_BUS_CTRL_WPROT_EN
        blocked = bus.req_we && (bus.req_addr >= ROM_BASE);
`else
        blocked = 1'b0;
`endif
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        en_d    = en_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        rv_d    = 1'b0;
        rdata_d = rdata_q;
`ifdef MEM_BUS_CTRL_WPROT_EN
        blk_d   = blk_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (bus.req_valid && ready_q) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    we_d    = bus.req_we;
                    en_d    = !blocked;
                    wen_d   = bus.req_we && !blocked;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = ACCESS;
`ifdef MEM_BUS_CTRL_WPROT_EN
                    blk_d   = blocked;
`endif
                end
            end
            ACCESS: begin
                if (we_q) begin
                    en_d    = 1'b0;
                    wen_d   = 1'b0;
                    rv_d    = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
`ifdef MEM_BUS_CTRL_WPROT_EN
                    err_d   = blk_q;
`endif
                // Counter reads 0 only on the first wait edge (T1), where it is
                // loaded; capture happens when it has counted down to 1.
                end else if (cnt_q == '0) begin
                    cnt_d = CNT_W'(RD_LATENCY);
                end else if (cnt_q == CNT_W'(1)) begin
                    rdata_d = mem_rd_data;
                    en_d    = 1'b0;
                    rv_d    = 1'b1;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == ACCESS);
    end

    // State and output registers; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            rv_q    <= 1'b0;
            rdata_q <= '0;
`ifdef MEM_BUS_CTRL_WPROT_EN
            blk_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            rv_q    <= rv_d;
            rdata_q <= rdata_d;
`ifdef MEM_BUS_CTRL_WPROT_EN
            blk_q   <= blk_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rv_q;
    assign bus.rsp_rdata = rdata_q;
`ifdef MEM_BUS_CTRL_WPROT_EN
    assign bus.rsp_err   = err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif
    assign busy          = busy_q;
    assign mem_enable    = en_q;
    assign mem_wr_enable = wen_q;
    assign mem_address   = addr_q;
    assign mem_wr_data   = wdata_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: two instances (RD_LATENCY 1 and 3),
// each with its own byte-wide memory model.
module tb_mem_bus_ctrl;

`ifdef MEM_BUS_CTRL_WPROT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        req_valid;
    logic        req_we;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    int          sel;

    mem_bus_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus1 ();
    mem_bus_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus3 ();

    logic        busy1, en1, wen1, busy3, en3, wen3;
    logic [15:0] addr1, addr3;
    logic [7:0]  wd1, rd1, wd3, rd3;
    logic [7:0]  mem1 [0:65535];
    logic [7:0]  mem3 [0:65535];

    assign bus1.req_valid = req_valid && (sel == 0);
    assign bus3.req_valid = req_valid && (sel == 1);
    assign bus1.req_we    = req_we;
    assign bus3.req_we    = req_we;
    assign bus1.req_addr  = req_addr;
    assign bus3.req_addr  = req_addr;
    assign bus1.req_wdata = req_wdata;
    assign bus3.req_wdata = req_wdata;

    mem_bus_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .RD_LATENCY(1)) dut1 (
        .clk(clk), .resetn(resetn), .bus(bus1.slave), .busy(busy1),
        .mem_enable(en1), .mem_address(addr1), .mem_wr_enable(wen1),
        .mem_wr_data(wd1), .mem_rd_data(rd1)
    );

    mem_bus_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .RD_LATENCY(3)) dut3 (
        .clk(clk), .resetn(resetn), .bus(bus3.slave), .busy(busy3),
        .mem_enable(en3), .mem_address(addr3), .mem_wr_enable(wen3),
        .mem_wr_data(wd3), .mem_rd_data(rd3)
    );

    // Synchronous memory models: sample on enable, one-edge read data.
    always @(posedge clk) begin
        if (en1) begin
            if (wen1) mem1[addr1] <= wd1;
            rd1 <= mem1[addr1];
        end
        if (en3) begin
            if (wen3) mem3[addr3] <= wd3;
            rd3 <= mem3[addr3];
        end
    end

    logic       o_ready, o_rv, o_err, o_busy, o_en, o_wen;
    logic [7:0] o_rdata;
    assign o_ready = (sel == 0) ? bus1.req_ready : bus3.req_ready;
    assign o_rv    = (sel == 0) ? bus1.rsp_valid : bus3.rsp_valid;
    assign o_err   = (sel == 0) ? bus1.rsp_err   : bus3.rsp_err;
    assign o_rdata = (sel == 0) ? bus1.rsp_rdata : bus3.rsp_rdata;
    assign o_busy  = (sel == 0) ? busy1 : busy3;
    assign o_en    = (sel == 0) ? en1   : en3;
    assign o_wen   = (sel == 0) ? wen1  : wen3;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        @(negedge clk);
        for (int i = 0; i < 20 && !o_ready; i++) @(negedge clk);
        chk("ready_wait", int'(o_ready), 1);
    endtask

    typedef struct {
        int         sel;
        logic       we;
        logic [15:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    task automatic run_txn(input vec_t v);
        int lat, en_cnt, wen_cnt, lat_n;
        bit got;
        sel   = v.sel;
        lat_n = (v.sel == 0) ? 1 : 3;
        wait_ready();
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("accept_busy", int'(o_busy), 1);
        chk("accept_ready", int'(o_ready), 0);
        en_cnt  = int'(o_en);
        wen_cnt = int'(o_wen);
        lat     = 0;
        got     = 1'b0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(posedge clk); #1;
            lat = i;
            en_cnt  += int'(o_en);
            wen_cnt += int'(o_wen);
            if (o_rv) got = 1'b1;
        end
        chk("rsp_seen", int'(got), 1);
        chk("rsp_latency", lat, v.we ? 1 : lat_n + 1);
        chk("en_cycles", en_cnt, v.we ? (v.exp_err ? 0 : 1) : lat_n + 1);
        chk("wen_cycles", wen_cnt, (v.we && !v.exp_err) ? 1 : 0);
        chk("rsp_err", int'(o_err), int'(v.exp_err));
        if (!v.we) chk("rsp_rdata", int'(o_rdata), int'(v.exp_rdata));
        @(posedge clk); #1;
        chk("rsp_pulse_width", int'(o_rv), 0);
        chk("ready_after", int'(o_ready), 1);
    endtask

    vec_t vecs[8];
    int   exp_rv[6]    = '{0, 1, 0, 0, 1, 0};
    int   exp_busy[6]  = '{1, 0, 1, 1, 0, 0};
    int   exp_ready[6] = '{0, 1, 0, 0, 1, 1};

    initial begin
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        sel       = 0;
        for (int i = 0; i < 65536; i++) begin
            mem1[i] = 8'h00;
            mem3[i] = 8'h00;
        end
        mem1[16'h0200] = 8'hA9;
        mem1[16'hFFFC] = 8'h11;
        mem3[16'h0300] = 8'h3C;
        rd1 = 8'h00;
        rd3 = 8'h00;

        vecs[0] = '{0, 1'b0, 16'h0200, 8'h00, 8'hA9, 1'b0};
        vecs[1] = '{0, 1'b1, 16'h0010, 8'h55, 8'h00, 1'b0};
        vecs[2] = '{0, 1'b0, 16'h0010, 8'h00, 8'h55, 1'b0};
        vecs[3] = '{0, 1'b1, 16'hFFFC, 8'h77, 8'h00, WPROT};
        vecs[4] = '{0, 1'b0, 16'hFFFC, 8'h00, WPROT ? 8'h11 : 8'h77, 1'b0};
        vecs[5] = '{0, 1'b1, 16'hEFFF, 8'h12, 8'h00, 1'b0};
        vecs[6] = '{0, 1'b0, 16'hEFFF, 8'h00, 8'h12, 1'b0};
        vecs[7] = '{1, 1'b0, 16'h0300, 8'h00, 8'h3C, 1'b0};

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready1", int'(bus1.req_ready), 0);
        chk("rst_busy1", int'(busy1), 0);
        chk("rst_en1", int'(en1), 0);
        chk("rst_wen1", int'(wen1), 0);
        chk("rst_rv1", int'(bus1.rsp_valid), 0);
        chk("rst_addr1", int'(addr1), 0);
        chk("rst_rdata1", int'(bus1.rsp_rdata), 0);
        chk("rst_ready3", int'(bus3.req_ready), 0);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("rel_ready1", int'(bus1.req_ready), 1);
        chk("rel_ready3", int'(bus3.req_ready), 1);

        // Table of single transactions.
        for (int i = 0; i < 8; i++) run_txn(vecs[i]);
        chk("mem_fffc", int'(mem1[16'hFFFC]), WPROT ? 32'h11 : 32'h77);

        // Back-to-back reads with req_valid held high.
        sel = 0;
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 16'h0200;
        @(posedge clk); #1;
        req_addr  = 16'h0010;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b_rv_e%0d", e), int'(o_rv), exp_rv[e-1]);
            chk($sformatf("b2b_busy_e%0d", e), int'(o_busy), exp_busy[e-1]);
            chk($sformatf("b2b_ready_e%0d", e), int'(o_ready), exp_ready[e-1]);
            if (e == 2) chk("b2b_rdata1", int'(o_rdata), 32'hA9);
            if (e == 5) chk("b2b_rdata2", int'(o_rdata), 32'h55);
            if (e == 3) req_valid = 1'b0;
        end

        // Reset asserted during the read wait on the latency-3 instance.
        sel = 1;
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 16'h0300;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("mid_en", int'(o_en), 1);
        chk("mid_rv", int'(o_rv), 0);
        #2 resetn = 1'b0;
        #1;
        chk("arst_en", int'(o_en), 0);
        chk("arst_ready", int'(o_ready), 0);
        chk("arst_busy", int'(o_busy), 0);
        for (int e = 0; e < 3; e++) begin
            @(posedge clk); #1;
            chk("arst_no_rsp", int'(o_rv), 0);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", int'(o_ready), 1);
        chk("post_rst_rv", int'(o_rv), 0);
        chk("post_rst_rdata", int'(o_rdata), 0);
        for (int e = 0; e < 4; e++) begin
            @(posedge clk); #1;
            chk("post_rst_no_rsp", int'(o_rv), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Bus-side controller that sits directly upstream of the 64kB memory model and downstream of the 6502 core's address/data unit. It accepts one byte read or write per valid/ready handshake and drives the memory's enable/address/wr_enable/wr_data pins with correctly timed registered strobes. It waits a programmable read latency, captures rd_data, and returns a single-cycle response pulse.

Parameters:
ADDR_WIDTH, 16, address bits (matches memory DEPTH)
DATA_WIDTH, 8, data bits (matches memory WIDTH)
RD_LATENCY, 1, edges after the memory's sampling edge before rd_data is captured; must be >=1, elaboration $error if 0
ROM_BASE, 16'hF000, lowest write-protected address (used only with the optional feature)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_addr  in  ADDR_WIDTH  request address
req_we  in  1  1=write, 0=read
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_WIDTH  read data; holds its value until the next read completes
rsp_err  out  1  write blocked (optional feature); valid with rsp_valid
busy  out  1  transaction in flight
mem_enable  out  1  to memory enable
mem_address  out  ADDR_WIDTH  to memory address
mem_wr_enable  out  1  to memory wr_enable
mem_wr_data  out  DATA_WIDTH  to memory wr_data
mem_rd_data  in  DATA_WIDTH  from memory rd_data

Behaviour:
- Reset (async, resetn=0): state IDLE; all outputs registered and cleared to 0, including req_ready; latency counter 0; any in-flight transaction is dropped with no rsp_valid.
- After release: req_ready rises at the first clk edge.
- FSM states:
  - IDLE: req_ready=1.
  - ACCESS: req_ready=0, busy=1.
- Accept at edge T0 when req_valid && req_ready:
  - latch addr/we/wdata;
  - drive mem_address and mem_wr_data from the latch;
  - set mem_enable=1 and mem_wr_enable=req_we;
  - set req_ready=0 and go to ACCESS.
  - req_* are ignored while req_ready=0.
- Write: the memory samples at T1. At T1: mem_enable and mem_wr_enable drop to 0, rsp_valid=1 for the cycle T1..T2, rsp_err=0, state returns to IDLE, and req_ready=1. The next request can be accepted at T2.
- Read: mem_enable is held high and mem_address is held stable. A counter is loaded with RD_LATENCY at T1 and decrements each edge. At edge T1+RD_LATENCY: capture mem_rd_data into rsp_rdata, drop mem_enable, pulse rsp_valid for one cycle, return to IDLE, set req_ready=1.
- Read timing: accept-to-rsp_valid is RD_LATENCY+1 edges, and mem_enable is high for RD_LATENCY+1 cycles.
- No response backpressure: the consumer must take rsp_valid when it occurs.
- mem_wr_data holds its last value when idle. mem_address wraps naturally at 2^ADDR_WIDTH; no range checks except the optional feature.
- busy = (state==ACCESS), registered.

Optional Feature:
MEM_BUS_CTRL_WPROT_EN
- Defined:
  - A write with req_addr >= ROM_BASE is blocked: mem_enable and mem_wr_enable stay 0.
  - rsp_valid still pulses at T1 with rsp_err=1, and memory is untouched.
  - Reads are unaffected.
- Undefined: rsp_err is tied to 0 and all writes proceed.

Decomposition:
- Package mem_bus_pkg holds: state enum (IDLE, ACCESS), default ADDR_WIDTH/DATA_WIDTH localparams, and default ROM_BASE.
- Latency counter width is $clog2(RD_LATENCY+1), computed locally.
- Single module; no sub-module is warranted.

Test Plan:
- Reset, RD_LATENCY=1, memory preloaded 0xA9 at 0x0200; read 0x0200 accepted at T0 -> mem_enable high T0..T2, rsp_valid in cycle T2..T3, rsp_rdata=0xA9, rsp_err=0.
- Write 0x55 to 0x0010, then read 0x0010 -> mem_wr_enable high exactly one cycle, write rsp_valid in T1..T2, readback 0x55.
- RD_LATENCY=3, read 0x0300 (preload 0x3C) -> rsp_valid 4 edges after accept, mem_enable high 4 cycles, rsp_rdata=0x3C.
- req_valid held through two back-to-back reads -> second accepted at the edge ending the first rsp_valid cycle; each rsp_valid is exactly one cycle.
- resetn pulled low mid-read during the wait -> mem_enable/req_ready go 0 immediately, no rsp_valid; req_ready=1 at the first edge after release.
- WPROT_EN with write 0x77 to 0xFFFC -> rsp_valid with rsp_err=1, mem_enable never high, memory unchanged. Without the macro -> write lands, rsp_err=0.
